// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Brief    : Register file with a pending-producer scoreboard, combinational
//            read ports and a sticky write-back error flag. Optional
//            write-back-to-read bypass is enabled by macro REG_FILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     wb_err
);

  // Register 0 is hardwired to zero, so storage and pending bits start at 1.
  logic [DATA_W-1:0] r_regs [1:DEPTH-1];
  logic [DEPTH-1:1]  r_pend;
  logic              r_err;

  logic [DEPTH-1:1]  w_wb_sel;
  logic [DEPTH-1:1]  w_rsv_sel;
  logic              w_wb_idle;

  // One-hot decode; addresses 0 and >= DEPTH match nothing and are ignored.
  always_comb begin
    w_wb_sel  = '0;
    w_rsv_sel = '0;
    for (int j = 1; j < DEPTH; j++) begin
      w_wb_sel[j]  = wb_en  && (wb_addr  == ADDR_W'(j));
      w_rsv_sel[j] = rsv_en && (rsv_addr == ADDR_W'(j));
    end
  end

  assign w_wb_idle = |(w_wb_sel & ~r_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 1; j < DEPTH; j++) begin
        r_regs[j] <= '0;
      end
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int j = 1; j < DEPTH; j++) begin
        if (w_wb_sel[j]) begin
          r_regs[j] <= wb_data;
        end
      end
      // A reservation in the same cycle as a write-back wins: new producer.
      r_pend <= (r_pend & ~w_wb_sel) | w_rsv_sel;
      if (w_wb_idle) begin
        r_err <= 1'b1;
      end
    end
  end

  assign wb_err = r_err;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_ready;

    assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      w_data  = '0;
      w_ready = 1'b1;
      for (int j = 1; j < DEPTH; j++) begin
        if (w_addr == ADDR_W'(j)) begin
          w_data  = r_regs[j];
          w_ready = !r_pend[j];
        end
      end
`ifdef REG_FILE_BYPASS_EN
      if ((|w_wb_sel) && (w_addr == wb_addr)) begin
        w_data  = wb_data;
        w_ready = 1'b1;
      end
`endif
    end

    assign rd_data[i*DATA_W +: DATA_W] = w_data;
    assign rd_ready[i]                 = w_ready;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Brief    : Randomized and directed bench for reg_file_sb (DEPTH 32 and 16)
//            against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_ready_a, rd_ready_b;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_err_a, wb_err_b;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] m_regs [2][32];
  bit          m_pend [2][32];
  bit          m_err  [2];
  int          dep    [2] = '{32, 16};

  reg_file_sb #(.ADDR_W(5), .DATA_W(32), .DEPTH(32), .NUM_RD(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_ready(rd_ready_a), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_err(wb_err_a)
  );

  reg_file_sb #(.ADDR_W(5), .DATA_W(32), .DEPTH(16), .NUM_RD(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_ready(rd_ready_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_err(wb_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 1'b0;
      for (int a = 0; a < 32; a++) begin
        m_regs[k][a] = '0;
        m_pend[k][a] = 1'b0;
      end
    end
  endfunction

  // Architectural effect of one rising edge with the current inputs.
  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      if (wb_en && wb_addr != 0 && int'(wb_addr) < dep[k]) begin
        if (!m_pend[k][wb_addr]) m_err[k] = 1'b1;
        m_regs[k][wb_addr] = wb_data;
        m_pend[k][wb_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0 && int'(rsv_addr) < dep[k])
        m_pend[k][rsv_addr] = 1'b1;
    end
  endfunction

  function automatic void model_read(input int k, input int a,
                                     output logic [31:0] d, output logic r);
    if (a == 0 || a >= dep[k]) begin
      d = '0;
      r = 1'b1;
    end else begin
      d = m_regs[k][a];
      r = !m_pend[k][a];
`ifdef REG_FILE_BYPASS_EN
      if (wb_en && int'(wb_addr) == a) begin
        d = wb_data;
        r = 1'b1;
      end
`endif
    end
  endfunction

  task automatic check_all();
    logic [31:0] ed;
    logic        er;
    int          a;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        a = int'(rd_addr[p*5 +: 5]);
        model_read(k, a, ed, er);
        chk($sformatf("d%0d p%0d data x%0d", dep[k], p, a),
            (k == 0) ? rd_data_a[p*32 +: 32] : rd_data_b[p*32 +: 32], ed);
        chk($sformatf("d%0d p%0d ready x%0d", dep[k], p, a),
            {31'd0, (k == 0) ? rd_ready_a[p] : rd_ready_b[p]}, {31'd0, er});
      end
      chk($sformatf("d%0d wb_err", dep[k]),
          {31'd0, (k == 0) ? wb_err_a : wb_err_b}, {31'd0, m_err[k]});
    end
  endtask

  // Called 1 ns after a rising edge with inputs already driven.
  task automatic step();
    #3;
    check_all();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle();
    rsv_en = 1'b0; wb_en = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic run_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rsv_en   = ($urandom_range(0, 1) == 1);
      rsv_addr = 5'($urandom_range(0, 31));
      wb_en    = ($urandom_range(0, 2) != 0);
      wb_addr  = ($urandom_range(0, 1) == 1) ? rsv_addr : 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      set_rd($urandom_range(0, 31),
             ($urandom_range(0, 1) == 1) ? int'(wb_addr) : int'($urandom_range(0, 31)));
      step();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; rsv_addr = '0; wb_addr = '0; wb_data = '0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      #1;
      check_all();
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int a = 0; a < 32; a++) begin
      set_rd(a, a);
      step();
    end

    run_random(200);

    // Reserve x5, observe not-ready, write back, observe ready.
    rsv_en = 1'b1; rsv_addr = 5'd5; set_rd(5, 5); step(); idle();
    set_rd(5, 0); step();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF; step(); idle();
    step();

    // Write-back to pending x7 while port 1 reads it.
    rsv_en = 1'b1; rsv_addr = 5'd7; step(); idle();
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_1234; set_rd(0, 7); step(); idle();
    step();

    // Reset so the sticky error starts clear for the collision case.
    rst_n = 1'b0; model_reset(); #1; check_all();
    @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;

    // Register 0 and out-of-range (for DEPTH 16) write-backs are ignored.
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0; set_rd(0, 0); step(); idle();
    step();
    rsv_en = 1'b1; rsv_addr = 5'd20; step(); idle();
    wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'hCAFEF00D; set_rd(20, 0); step(); idle();
    step();

    // Reserve and write back x9 together while not pending: error, stays pending.
    rsv_en = 1'b1; rsv_addr = 5'd9; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    set_rd(9, 9); step(); idle();
    repeat (3) step();

    run_random(150);

    // Reset asserted mid-cycle with a reservation in flight.
    rsv_en = 1'b1; rsv_addr = 5'd3; step();
    set_rd(3, 3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk); #1;
    check_all();
    idle();
    @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
    step();
    rsv_en = 1'b1; rsv_addr = 5'd3; step(); idle();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5A5_0003; step(); idle();
    step();

    run_random(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
